// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - key event valid/ready pop interface
interface ps2_keyboard_rx_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_brk;
  logic       key_ext;

  modport master (
    output key_valid,
    output key_code,
    output key_brk,
    output key_ext,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_brk,
    input  key_ext,
    output key_ready
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through FIFO of key events
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       reset_btn,
  input  logic       push_i,
  input  key_event_t push_data_i,
  input  logic       pop_i,
  output key_event_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  key_event_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 set-2 keyboard receiver; PS2_PARITY_CHECK_EN enables parity rejection
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic              clk_in,
  input  logic              reset_btn,
  input  logic              ps2_clock,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master key_if,
  output logic              frame_err,
  output logic              overflow
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_filt_q, clk_filt_d;
  logic [CW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          push;
  key_event_t    push_ev, head_ev;
  logic          fifo_full, fifo_empty, pop;
  logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Filtered clock follows the synchronised clock only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == CW'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall = clk_filt_q && !clk_filt_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_ev     = '0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + 1'b1;

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && parity_ok) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
              brk_d = 1'b1;
            end else begin
              push    = 1'b1;
              push_ev = '{ext: ext_q, brk: brk_q, code: shift_q};
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q >= TW'(TIMEOUT_CYCLES)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    // A broken frame leaves any half-seen prefix sequence meaningless.
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  assign pop        = key_if.key_valid && key_if.key_ready;
  assign overflow_d = push && fifo_full && !pop;

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_s1_q    <= ps2_clock;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .reset_btn  (reset_btn),
    .push_i     (push),
    .push_data_i(push_ev),
    .pop_i      (pop),
    .head_o     (head_ev),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign key_if.key_valid = !fifo_empty;
  assign key_if.key_code  = fifo_empty ? 8'h00 : head_ev.code;
  assign key_if.key_brk   = !fifo_empty && head_ev.brk;
  assign key_if.key_ext   = !fifo_empty && head_ev.ext;
  assign frame_err        = frame_err_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx with a queue-based keyboard model
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int HALF  = 40;
  localparam int QTR   = 20;
  localparam int DEPTH = 4;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk_in    = 1'b0;
  logic reset_btn = 1'b1;
  logic ps2_clock = 1'b1;
  logic ps2_data  = 1'b1;
  logic frame_err, overflow;

  ps2_keyboard_rx_if kif ();

  // 1 MHz system clock keeps a 12.5 kHz PS/2 bit at 80 cycles.
  always #500 clk_in = ~clk_in;

  ps2_keyboard_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(2000),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_in   (clk_in),
    .reset_btn(reset_btn),
    .ps2_clock(ps2_clock),
    .ps2_data (ps2_data),
    .key_if   (kif),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  int          errors = 0;
  int          checks = 0;
  key_event_t  exp_q[$];
  logic [7:0]  popped[$];
  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;
  int          exp_ferr = 0, exp_ovf = 0;
  int          ferr_seen = 0, ovf_seen = 0, n_pops = 0;
  logic [9:0]  last_ev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Keyboard-side model: what a host must report for each frame the bench sends.
  task automatic model_frame_end(input logic [7:0] b, input bit ok);
    key_event_t ev;
    if (!ok) begin
      exp_ferr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      ev.ext  = m_ext;
      ev.brk  = m_brk;
      ev.code = b;
      if (exp_q.size() == DEPTH) exp_ovf++;
      else exp_q.push_back(ev);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(5);
        ps2_clock = 1'b0;
        wait_cyc(1);
        ps2_clock = 1'b1;
        wait_cyc(QTR - 6);
      end else begin
        wait_cyc(QTR);
      end
      ps2_clock = 1'b0;
      if (i == 10) model_frame_end(b, !bad_stop && (!bad_par || !PAR_EN));
      if (glitch) begin
        wait_cyc(20);
        ps2_clock = 1'b1;
        wait_cyc(2);
        ps2_clock = 1'b0;
        wait_cyc(HALF - 22);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clock = 1'b1;
      wait_cyc(QTR);
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_partial(input int ndata);
    logic [8:0] bits;
    bits = {8'h55, 1'b0};
    for (int i = 0; i <= ndata; i++) begin
      ps2_data = bits[i];
      wait_cyc(QTR);
      ps2_clock = 1'b0;
      wait_cyc(HALF);
      ps2_clock = 1'b1;
      wait_cyc(QTR);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_key_valid"}, kif.key_valid, 0);
    chk({tag, "_key_code"}, kif.key_code, 0);
    chk({tag, "_key_brk_ext"}, {kif.key_brk, kif.key_ext}, 0);
    chk({tag, "_pulses"}, {frame_err, overflow}, 0);
  endtask

  always @(negedge clk_in) begin
    key_event_t e;
    if (!reset_btn) begin
      if (frame_err) ferr_seen++;
      if (overflow) ovf_seen++;
      if (kif.key_valid && kif.key_ready) begin
        chk("pop_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pop_event", {kif.key_ext, kif.key_brk, kif.key_code}, e);
        end
        last_ev = {kif.key_ext, kif.key_brk, kif.key_code};
        popped.push_back(kif.key_code);
        n_pops++;
      end
    end
  end

  initial begin
    #(80_000 * 1000);
    $display("FAIL watchdog: run exceeded 80000 cycles");
    $fatal(1);
  end

  initial begin
    int p;
    kif.key_ready = 1'b0;
    wait_cyc(5);
    chk_outputs_zero("reset");
    reset_btn = 1'b0;
    wait_cyc(20);
    chk("idle_key_valid", kif.key_valid, 0);

    kif.key_ready = 1'b1;
    send_frame(8'h1C, 0, 0, 0);
    wait_cyc(100);
    chk("t1_event", last_ev, 10'h01C);
    chk("t1_no_frame_err", ferr_seen, 0);

    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    p = n_pops;
    send_frame(8'h75, 0, 0, 0);
    wait_cyc(100);
    chk("t2_one_event", n_pops - p, 1);
    chk("t2_event", last_ev, 10'h375);
    send_frame(8'h75, 0, 0, 0);
    wait_cyc(100);
    chk("t2_flags_cleared", last_ev, 10'h075);

    p = n_pops;
    send_frame(8'h1C, 0, 1, 0);
    wait_cyc(100);
    chk("t3_frame_err", ferr_seen, 1);
    chk("t3_no_event", n_pops - p, 0);
    send_frame(8'h1C, 0, 0, 0);
    wait_cyc(100);
    chk("t3_recover", last_ev, 10'h01C);

    p = n_pops;
    send_frame(8'h3B, 1, 0, 0);
    wait_cyc(100);
    chk("t4_frame_err_model", ferr_seen, exp_ferr);
`ifdef PS2_PARITY_CHECK_EN
    chk("t4_no_event", n_pops - p, 0);
`else
    chk("t4_event", last_ev, 10'h03B);
`endif

    send_partial(4);
    exp_ferr++;
    wait_cyc(3000);
    chk("t5_timeout_err", ferr_seen, exp_ferr);
    send_frame(8'h2A, 0, 0, 0);
    wait_cyc(100);
    chk("t5_recover", last_ev, 10'h02A);

    send_frame(8'h5A, 0, 0, 1);
    wait_cyc(100);
    chk("glitch_event", last_ev, 10'h05A);

    kif.key_ready = 1'b0;
    popped.delete();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 0, 0, 0);
    wait_cyc(100);
    chk("t6_overflow", ovf_seen, 1);
    chk("t6_overflow_model", ovf_seen, exp_ovf);
    chk("t6_head", {kif.key_valid, kif.key_code}, 9'h101);
    kif.key_ready = 1'b1;
    wait_cyc(20);
    chk("t6_pop_count", popped.size(), 4);
    for (int k = 0; k < popped.size(); k++) chk("t6_pop_order", popped[k], k + 1);
    chk("t6_drained_valid", kif.key_valid, 0);

    kif.key_ready = 1'b0;
    send_frame(8'h16, 0, 0, 0);
    wait_cyc(50);
    chk("rst_pre_valid", kif.key_valid, 1);
    send_partial(5);
    reset_btn = 1'b1;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(2);
    chk_outputs_zero("midreset");
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    wait_cyc(20);
    reset_btn = 1'b0;
    wait_cyc(50);
    chk("rst_post_valid", kif.key_valid, 0);
    kif.key_ready = 1'b1;
    send_frame(8'h1C, 0, 0, 0);
    wait_cyc(100);
    chk("rst_recover", last_ev, 10'h01C);

    chk("final_frame_err", ferr_seen, exp_ferr);
    chk("final_overflow", ovf_seen, exp_ovf);
    chk("final_model_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
